// File: rtl/param_fifo.sv
// Parametrised synchronous FIFO with occupancy count, threshold flags and error pulses.
// Define FIFO_FWFT_EN for first-word-fall-through reads; otherwise reads have 1-cycle latency.
module param_fifo #(
   parameter int DATA_W = 10,
   parameter int ADDR_W = 3,
   parameter int AF_LVL = 6,
   parameter int AE_LVL = 2
) (
   input  logic              CLK,
   input  logic              RST_N,
   input  logic [DATA_W-1:0] Din,
   input  logic              WR_EN,
   input  logic              RD_EN,
   output logic [DATA_W-1:0] Dout,
   output logic              Empty,
   output logic              Full,
   output logic              AlmostFull,
   output logic              AlmostEmpty,
   output logic [ADDR_W:0]   Count,
   output logic              Overflow,
   output logic              Underflow
);

   localparam int DEPTH = 2 ** ADDR_W;
   localparam logic [ADDR_W:0] DEPTH_C = ADDR_W'(0) + (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W:0] AF_C = (ADDR_W+1)'(AF_LVL);
   localparam logic [ADDR_W:0] AE_C = (ADDR_W+1)'(AE_LVL);
   localparam logic AF_RST = (AF_LVL == 0);

   logic [DATA_W-1:0] mem [DEPTH];

   logic [ADDR_W:0] wptr;
   logic [ADDR_W:0] rptr;
   logic [ADDR_W:0] wptr_next;
   logic [ADDR_W:0] rptr_next;
   logic [ADDR_W:0] count_next;

   logic rd_ok;
   logic wr_ok;

   // Acceptance: a read needs data; a write needs room or a same-cycle pop.
   always_comb begin
      rd_ok = RD_EN && !Empty;
      wr_ok = WR_EN && (!Full || rd_ok);
   end

   // Next pointers and occupancy from the accepted operations.
   always_comb begin
      wptr_next = wptr;
      rptr_next = rptr;
      count_next = Count;
      if (wr_ok)
         wptr_next = wptr + 1'b1;
      if (rd_ok)
         rptr_next = rptr + 1'b1;
      unique case ({wr_ok, rd_ok})
         2'b10:   count_next = Count + 1'b1;
         2'b01:   count_next = Count - 1'b1;
         default: count_next = Count;
      endcase
   end

   // Storage array; contents are not reset and only become visible via pointers.
   always_ff @(posedge CLK) begin
      if (wr_ok)
         mem[wptr[ADDR_W-1:0]] <= Din;
   end

   // Pointer and count registers.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         wptr  <= '0;
         rptr  <= '0;
         Count <= '0;
      end else begin
         wptr  <= wptr_next;
         rptr  <= rptr_next;
         Count <= count_next;
      end
   end

   // Status flags registered from the next-state count so they align with Count.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         Empty       <= 1'b1;
         Full        <= 1'b0;
         AlmostFull  <= AF_RST;
         AlmostEmpty <= 1'b1;
      end else begin
         Empty       <= (count_next == '0);
         Full        <= (count_next == DEPTH_C);
         AlmostFull  <= (count_next >= AF_C);
         AlmostEmpty <= (count_next <= AE_C);
      end
   end

   // Error pulses last exactly one cycle after the rejected request.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         Overflow  <= 1'b0;
         Underflow <= 1'b0;
      end else begin
         Overflow  <= WR_EN && !wr_ok;
         Underflow <= RD_EN && !rd_ok;
      end
   end

`ifdef FIFO_FWFT_EN
   logic              head_live;
   logic [DATA_W-1:0] head_next;

   // Head after this edge; a word landing in the head slot is bypassed from Din.
   always_comb begin
      head_live = (count_next != '0);
      head_next = mem[rptr_next[ADDR_W-1:0]];
      if (wr_ok && (rptr_next == wptr))
         head_next = Din;
   end

   // Dout tracks the head while data is present and holds when drained.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N)
         Dout <= '0;
      else if (head_live)
         Dout <= head_next;
   end
`else
   // Registered read: head word appears one edge after an accepted read.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N)
         Dout <= '0;
      else if (rd_ok)
         Dout <= mem[rptr[ADDR_W-1:0]];
   end
`endif

endmodule

// File: tb/tb_param_fifo.sv
// Self-checking bench for param_fifo: vector table, directed corners,
// and randomised traffic against a queue-based reference model.
module tb_param_fifo;

   localparam int DW = 10;
   localparam int AW = 3;
   localparam int DEPTH = 8;
   localparam int AFL = 6;
   localparam int AEL = 2;

   logic          CLK;
   logic          RST_N;
   logic [DW-1:0] Din;
   logic          WR_EN;
   logic          RD_EN;
   logic [DW-1:0] Dout;
   logic          Empty;
   logic          Full;
   logic          AlmostFull;
   logic          AlmostEmpty;
   logic [AW:0]   Count;
   logic          Overflow;
   logic          Underflow;

   int total = 0;
   int bad = 0;

   int            q[$];
   logic [DW-1:0] m_dout;
   bit            m_ov;
   bit            m_un;

   param_fifo #(
      .DATA_W(DW), .ADDR_W(AW), .AF_LVL(AFL), .AE_LVL(AEL)
   ) dut (
      .CLK(CLK), .RST_N(RST_N), .Din(Din),
      .WR_EN(WR_EN), .RD_EN(RD_EN), .Dout(Dout),
      .Empty(Empty), .Full(Full),
      .AlmostFull(AlmostFull), .AlmostEmpty(AlmostEmpty),
      .Count(Count), .Overflow(Overflow), .Underflow(Underflow)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic chk(string name, int act, int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      q.delete();
      m_dout = '0;
      m_ov = 0;
      m_un = 0;
   endtask

   task automatic check_model();
      int n;
      n = q.size();
      chk("m_count", int'(Count), n);
      chk("m_empty", int'(Empty), int'(n == 0));
      chk("m_full", int'(Full), int'(n == DEPTH));
      chk("m_afull", int'(AlmostFull), int'(n >= AFL));
      chk("m_aempty", int'(AlmostEmpty), int'(n <= AEL));
      chk("m_ovf", int'(Overflow), int'(m_ov));
      chk("m_unf", int'(Underflow), int'(m_un));
      chk("m_dout", int'(Dout), int'(m_dout));
   endtask

   task automatic step(bit wr, bit rd, logic [DW-1:0] d);
      bit rok;
      bit wok;
      WR_EN = wr;
      RD_EN = rd;
      Din = d;
      @(posedge CLK);
      rok = rd && (q.size() > 0);
      wok = wr && ((q.size() < DEPTH) || rok);
      m_ov = wr && !wok;
      m_un = rd && !rok;
`ifndef FIFO_FWFT_EN
      if (rok) m_dout = DW'(q[0]);
`endif
      if (rok) void'(q.pop_front());
      if (wok) q.push_back(int'(d));
`ifdef FIFO_FWFT_EN
      if (q.size() > 0) m_dout = DW'(q[0]);
`endif
      #1;
      check_model();
      WR_EN = 1'b0;
      RD_EN = 1'b0;
   endtask

   typedef struct {
      bit wr; bit rd; logic [DW-1:0] din;
      int cnt; bit emp; bit ful; bit af; bit ae; bit ov; bit un;
      logic [DW-1:0] d_std; logic [DW-1:0] d_fw;
   } vec_t;

   vec_t vt[11];

   initial begin
      int got;
      int exp;
      vt[0]  = '{0,1,  0, 0,1,0,0,1,0,1,  0,  0};
      vt[1]  = '{0,0,  0, 0,1,0,0,1,0,0,  0,  0};
      vt[2]  = '{1,0, 32, 1,0,0,0,1,0,0,  0, 32};
      vt[3]  = '{1,0, 29, 2,0,0,0,1,0,0,  0, 32};
      vt[4]  = '{1,0, 53, 3,0,0,0,0,0,0,  0, 32};
      vt[5]  = '{0,1,  0, 2,0,0,0,1,0,0, 32, 29};
      vt[6]  = '{0,1,  0, 1,0,0,0,1,0,0, 29, 53};
      vt[7]  = '{0,1,  0, 0,1,0,0,1,0,0, 53, 53};
      vt[8]  = '{0,1,  0, 0,1,0,0,1,0,1, 53, 53};
      vt[9]  = '{1,1,  5, 1,0,0,0,1,0,1, 53,  5};
      vt[10] = '{0,1,  0, 0,1,0,0,1,0,0,  5,  5};

      RST_N = 1'b0;
      WR_EN = 1'b0;
      RD_EN = 1'b0;
      Din = '0;
      model_reset();
      repeat (2) @(posedge CLK);
      #1;
      chk("rst_count", int'(Count), 0);
      chk("rst_empty", int'(Empty), 1);
      chk("rst_full", int'(Full), 0);
      chk("rst_aempty", int'(AlmostEmpty), 1);
      chk("rst_afull", int'(AlmostFull), 0);
      chk("rst_ovf", int'(Overflow), 0);
      chk("rst_unf", int'(Underflow), 0);
      chk("rst_dout", int'(Dout), 0);
      #3 RST_N = 1'b1;

      for (int i = 0; i < 11; i++) begin
         step(vt[i].wr, vt[i].rd, vt[i].din);
         chk("v_count", int'(Count), vt[i].cnt);
         chk("v_empty", int'(Empty), int'(vt[i].emp));
         chk("v_full", int'(Full), int'(vt[i].ful));
         chk("v_afull", int'(AlmostFull), int'(vt[i].af));
         chk("v_aempty", int'(AlmostEmpty), int'(vt[i].ae));
         chk("v_ovf", int'(Overflow), int'(vt[i].ov));
         chk("v_unf", int'(Underflow), int'(vt[i].un));
`ifdef FIFO_FWFT_EN
         chk("v_dout", int'(Dout), int'(vt[i].d_fw));
`else
         chk("v_dout", int'(Dout), int'(vt[i].d_std));
`endif
      end

      for (int i = 1; i <= 8; i++) step(1, 0, DW'(i));
      chk("fill_full", int'(Full), 1);
      chk("fill_count", int'(Count), 8);
      step(1, 0, 10'd99);
      chk("ovf_pulse", int'(Overflow), 1);
      chk("ovf_count", int'(Count), 8);
      step(0, 0, 0);
      chk("ovf_clear", int'(Overflow), 0);
      step(1, 1, 10'd77);
      chk("rw_full_count", int'(Count), 8);
      chk("rw_full_ovf", int'(Overflow), 0);
      chk("rw_full_flag", int'(Full), 1);
      for (int k = 0; k < 8; k++) begin
         exp = (k < 7) ? k + 2 : 77;
`ifdef FIFO_FWFT_EN
         got = int'(Dout);
         step(0, 1, 0);
`else
         step(0, 1, 0);
         got = int'(Dout);
`endif
         chk("drain_order", got, exp);
      end
      chk("drain_empty", int'(Empty), 1);

      for (int i = 1; i <= 6; i++) begin
         step(1, 0, DW'(200 + i));
         if (i == 2) chk("th_ae_hold", int'(AlmostEmpty), 1);
         if (i == 3) chk("th_ae_drop", int'(AlmostEmpty), 0);
         if (i == 5) chk("th_af_low", int'(AlmostFull), 0);
         if (i == 6) chk("th_af_rise", int'(AlmostFull), 1);
      end
      for (int i = 1; i <= 4; i++) begin
         step(0, 1, 0);
         if (i == 1) chk("th_af_fall", int'(AlmostFull), 0);
         if (i == 3) chk("th_ae_low", int'(AlmostEmpty), 0);
         if (i == 4) chk("th_ae_back", int'(AlmostEmpty), 1);
      end
      step(0, 1, 0);
      step(0, 1, 0);

      for (int i = 0; i < 20; i++) begin
         step(1, 0, DW'(100 + i));
`ifdef FIFO_FWFT_EN
         chk("wrap_head", int'(Dout), 100 + i);
`endif
         step(0, 1, 0);
`ifndef FIFO_FWFT_EN
         chk("wrap_read", int'(Dout), 100 + i);
`endif
      end

      for (int i = 0; i < 5; i++) step(1, 0, DW'(300 + i));
      #3 RST_N = 1'b0;
      #1;
      model_reset();
      chk("arst_count", int'(Count), 0);
      chk("arst_empty", int'(Empty), 1);
      chk("arst_dout", int'(Dout), 0);
      #1 RST_N = 1'b1;
      step(1, 0, 10'd321);
`ifdef FIFO_FWFT_EN
      chk("arst_new", int'(Dout), 321);
`endif
      step(0, 1, 0);
`ifndef FIFO_FWFT_EN
      chk("arst_new", int'(Dout), 321);
`endif
      chk("arst_drained", int'(Empty), 1);

      for (int i = 0; i < 400; i++) begin
         bit w;
         bit r;
         w = ($urandom_range(0, 99) < 55);
         r = ($urandom_range(0, 99) < 50);
         step(w, r, DW'($urandom_range(0, 1023)));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
